// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int CLA_BLK_DEF    = 4;
    localparam int CLA_STAGES_DEF = 2;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } cla_mode_e;

    function automatic int num_blocks(input int k, input int blk);
        return (k + blk - 1) / blk;
    endfunction

    function automatic int blocks_per_stage(input int n, input int stages);
        return (n + stages - 1) / stages;
    endfunction

    // STAGES must be at least 1 and no larger than the number of blocks.
    function automatic bit stages_legal(input int k, input int blk, input int stages);
        return (stages >= 1) && (stages <= num_blocks(k, blk));
    endfunction

endpackage

// File: rtl/cla_blk.sv
// Combinational BLK-bit carry-lookahead block: sum, group generate/propagate,
// and the carry into bit TOP_BIT (the block's top meaningful bit).
module cla_blk #(
    parameter int BLK     = 4,
    parameter int TOP_BIT = BLK - 1
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           g,
    output logic           p,
    output logic           c_top
);

    logic [BLK-1:0] gb;
    logic [BLK-1:0] pb;
    logic [BLK-1:0] c;
    logic [1:0]     gp;
    logic [1:0]     gp_all;

    // Returns {generate, propagate} of the bit group 0..hi.
    function automatic logic [1:0] group_gp(input logic [BLK-1:0] gv,
                                            input logic [BLK-1:0] pv,
                                            input int hi);
        logic gg;
        logic pp;
        gg = 1'b0;
        pp = 1'b1;
        for (int j = 0; j <= hi; j++) begin
            gg = gv[j] | (pv[j] & gg);
            pp = pp & pv[j];
        end
        return {gg, pp};
    endfunction

    assign gb = a & b;
    assign pb = a ^ b;

    always_comb begin
        gp   = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 1; i < BLK; i++) begin
            gp   = group_gp(gb, pb, i - 1);
            c[i] = gp[1] | (gp[0] & cin);
        end
    end

    assign gp_all = group_gp(gb, pb, BLK - 1);
    assign g      = gp_all[1];
    assign p      = gp_all[0];
    assign sum    = pb ^ c;
    assign c_top  = c[TOP_BIT];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready backpressure.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int K      = 32,
    parameter int BLK    = CLA_BLK_DEF,
    parameter int STAGES = CLA_STAGES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] sum,
    output logic         cout
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int N        = num_blocks(K, BLK);
    localparam int BPS      = blocks_per_stage(N, STAGES);
    localparam int KP       = N * BLK;
    localparam int LS       = (N - 1) / BPS;
    localparam int LAST_TOP = (K - 1) % BLK;

    if (!stages_legal(K, BLK, STAGES)) begin : g_bad_stages
        $error("cla_pipe_addsub: STAGES must lie in 1..ceil(K/BLK)");
    end

    logic [KP-1:0]  a_p     [STAGES];
    logic [KP-1:0]  b_p     [STAGES];
    logic [KP-1:0]  sum_p   [STAGES];
    logic           c_p     [STAGES];
    logic           cout_p  [STAGES];
    logic           vld_p   [STAGES];

    logic [KP-1:0]  st_a    [STAGES];
    logic [KP-1:0]  st_b    [STAGES];
    logic [KP-1:0]  st_sum  [STAGES];
    logic           st_c    [STAGES];
    logic           st_cout [STAGES];
    logic           st_vld  [STAGES];

    logic [KP-1:0]  nx_sum  [STAGES];
    logic           nx_c    [STAGES];
    logic           nx_cout [STAGES];

    logic [BLK-1:0] blk_sum  [N];
    logic           blk_g    [N];
    logic           blk_p    [N];
    logic           blk_cin  [N];
    logic           blk_ctop [N];

    logic [K-1:0]   b_eff;
    logic           advance;
    logic           carry;
    logic           top_a;
    logic           top_b;
    logic           unused_tail;

`ifdef CLA_PIPE_OVF_EN
    logic           ovf_p   [STAGES];
    logic           st_ovf  [STAGES];
    logic           nx_ovf  [STAGES];
`endif

    // The whole pipe moves together; a held output freezes every stage.
    assign advance  = !vld_p[STAGES-1] || out_ready;
    assign in_ready = advance;

    // Stage inputs: effective operands enter stage 0, later stages read the previous registers.
    always_comb begin
        b_eff      = (sub == MODE_SUB) ? ~b : b;
        st_a[0]    = KP'(a);
        st_b[0]    = KP'(b_eff);
        st_sum[0]  = '0;
        st_c[0]    = (sub == MODE_SUB) ? ~cin : cin;
        st_cout[0] = 1'b0;
        st_vld[0]  = in_valid;
`ifdef CLA_PIPE_OVF_EN
        st_ovf[0]  = 1'b0;
`endif
        for (int s = 1; s < STAGES; s++) begin
            st_a[s]    = a_p[s-1];
            st_b[s]    = b_p[s-1];
            st_sum[s]  = sum_p[s-1];
            st_c[s]    = c_p[s-1];
            st_cout[s] = cout_p[s-1];
            st_vld[s]  = vld_p[s-1];
`ifdef CLA_PIPE_OVF_EN
            st_ovf[s]  = ovf_p[s-1];
`endif
        end
    end

    for (genvar n = 0; n < N; n++) begin : g_blk
        localparam int S = n / BPS;
        cla_blk #(
            .BLK     (BLK),
            .TOP_BIT ((n == N - 1) ? LAST_TOP : BLK - 1)
        ) u_blk (
            .a     (st_a[S][n*BLK +: BLK]),
            .b     (st_b[S][n*BLK +: BLK]),
            .cin   (blk_cin[n]),
            .sum   (blk_sum[n]),
            .g     (blk_g[n]),
            .p     (blk_p[n]),
            .c_top (blk_ctop[n])
        );
    end

    // Block carries ripple through group G/P inside a stage; each stage starts from its registered carry.
    always_comb begin
        carry = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            nx_c[s] = st_c[s];
        end
        for (int n = 0; n < N; n++) begin
            if (n % BPS == 0) begin
                carry = st_c[n / BPS];
            end
            blk_cin[n]    = carry;
            carry         = blk_g[n] | (blk_p[n] & carry);
            nx_c[n / BPS] = carry;
        end
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            nx_sum[s] = st_sum[s];
        end
        for (int n = 0; n < N; n++) begin
            nx_sum[n / BPS][n*BLK +: BLK] = blk_sum[n];
        end
    end

    // Carry into bit K comes from the bit K-1 inputs and the carry into it, so padding never masks it.
    always_comb begin
        top_a = st_a[LS][K-1];
        top_b = st_b[LS][K-1];
        for (int s = 0; s < STAGES; s++) begin
            nx_cout[s] = st_cout[s];
`ifdef CLA_PIPE_OVF_EN
            nx_ovf[s]  = st_ovf[s];
`endif
        end
        nx_cout[LS] = (top_a & top_b) | ((top_a ^ top_b) & blk_ctop[N-1]);
`ifdef CLA_PIPE_OVF_EN
        nx_ovf[LS]  = blk_ctop[N-1] ^ nx_cout[LS];
`endif
    end

    // Stage registers: sum slice, outgoing carry and skewed operands per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_p[s]  <= 1'b0;
                a_p[s]    <= '0;
                b_p[s]    <= '0;
                sum_p[s]  <= '0;
                c_p[s]    <= 1'b0;
                cout_p[s] <= 1'b0;
`ifdef CLA_PIPE_OVF_EN
                ovf_p[s]  <= 1'b0;
`endif
            end
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_p[s]  <= st_vld[s];
                a_p[s]    <= st_a[s];
                b_p[s]    <= st_b[s];
                sum_p[s]  <= nx_sum[s];
                c_p[s]    <= nx_c[s];
                cout_p[s] <= nx_cout[s];
`ifdef CLA_PIPE_OVF_EN
                ovf_p[s]  <= nx_ovf[s];
`endif
            end
        end
    end

    assign out_valid = vld_p[STAGES-1];
    assign sum       = sum_p[STAGES-1][K-1:0];
    assign cout      = cout_p[STAGES-1];
`ifdef CLA_PIPE_OVF_EN
    assign ovf       = ovf_p[STAGES-1];
`endif

    // Final-stage operand copies, padded sum bits and inner-block top carries have no consumer.
    always_comb begin
        unused_tail = ^{a_p[STAGES-1], b_p[STAGES-1], sum_p[STAGES-1], c_p[STAGES-1]};
        for (int n = 0; n < N; n++) begin
            unused_tail = unused_tail ^ blk_ctop[n];
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed self-checking bench: three instances (K=32/S=2, K=30/S=2, K=32/S=3) share one stimulus bus.
module tb_cla_pipe_addsub;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;

    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic [31:0] sum0, sum2;
    logic [29:0] sum1;
    logic        cout0, cout1, cout2;
`ifdef CLA_PIPE_OVF_EN
    logic        ovf0, ovf1, ovf2;
`endif

    logic        o_valid [3];
    logic [31:0] o_sum   [3];
    logic        o_cout  [3];
    logic        o_ovf   [3];
    logic        i_ready [3];

    int n_cmp;
    int n_bad;

    cla_pipe_addsub #(.K(32), .BLK(4), .STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(vld0), .out_ready(out_ready), .sum(sum0), .cout(cout0)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(ovf0)
`endif
    );

    cla_pipe_addsub #(.K(30), .BLK(4), .STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .a(a[29:0]), .b(b[29:0]), .cin(cin), .sub(sub),
        .out_valid(vld1), .out_ready(out_ready), .sum(sum1), .cout(cout1)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(ovf1)
`endif
    );

    cla_pipe_addsub #(.K(32), .BLK(4), .STAGES(3)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(vld2), .out_ready(out_ready), .sum(sum2), .cout(cout2)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(ovf2)
`endif
    );

    always_comb begin
        o_valid[0] = vld0;  o_valid[1] = vld1;  o_valid[2] = vld2;
        o_sum[0]   = sum0;  o_sum[1]   = {2'b00, sum1};  o_sum[2] = sum2;
        o_cout[0]  = cout0; o_cout[1]  = cout1; o_cout[2]  = cout2;
        i_ready[0] = rdy0;  i_ready[1] = rdy1;  i_ready[2] = rdy2;
`ifdef CLA_PIPE_OVF_EN
        o_ovf[0] = ovf0; o_ovf[1] = ovf1; o_ovf[2] = ovf2;
`else
        o_ovf[0] = 1'b0; o_ovf[1] = 1'b0; o_ovf[2] = 1'b0;
`endif
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    // One operation into an idle pipe; checks latency, sum, cout (and ovf when built in).
    task automatic run_op(input int sel, input string tag,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic sb,
                          input logic [31:0] es, input logic ec, input logic eo,
                          input int el);
        int lat;
        idle(4);
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, i_ready[sel], 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!o_valid[sel] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_sum"}, o_sum[sel], es);
        chk({tag, "_cout"}, o_cout[sel], ec);
`ifdef CLA_PIPE_OVF_EN
        chk({tag, "_ovf"}, o_ovf[sel], eo);
`else
        if (eo !== o_ovf[sel] && eo === 1'b0) chk({tag, "_ovf_absent"}, o_ovf[sel], 0);
`endif
    endtask

    logic [31:0] bp_exp [6];

    initial begin
        int sent, got, cyc, nres;
        logic stall_prev, saw_not_ready;
        logic [31:0] held_sum;

        n_cmp = 0; n_bad = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_out_valid", o_valid[i], 0);
            chk("reset_sum", o_sum[i], 0);
            chk("reset_cout", o_cout[i], 0);
            chk("reset_in_ready", i_ready[i], 1);
        end

        // Add mode, carries crossing block and stage boundaries.
        run_op(0, "add_carry_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2);
        run_op(0, "add_mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 2);
        run_op(2, "add_s3", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3);

        // K=30: carry-out is the carry into bit 30, not out of the padded block.
        run_op(1, "k30_wrap", 32'h3FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2);
        run_op(1, "k30_msb", 32'h2000_0000, 32'h2000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2);
        run_op(1, "k30_mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 2);
        run_op(1, "k30_sub", 32'h5, 32'h7, 1'b0, 1'b1, 32'h3FFF_FFFE, 1'b0, 1'b0, 2);

        // Subtract mode: cout is NOT borrow.
        run_op(0, "sub_borrow", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 2);
        run_op(0, "sub_bin", 32'h7, 32'h5, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 2);
        run_op(0, "sub_equal", 32'h5, 32'h5, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 2);
        run_op(0, "sub_equal_bin", 32'h5, 32'h5, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);

        // Signed overflow cases (ovf only compared when the feature is built in).
        run_op(0, "ovf_add_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 2);
        run_op(0, "ovf_sub_neg", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 2);
        run_op(0, "ovf_none", 32'h3, 32'h1, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 2);

        // Backpressure on the 3-stage instance: 6 back-to-back ops, out_ready low for 4 cycles.
        for (int i = 0; i < 6; i++) begin
            bp_exp[i] = 32'h1111_1111 * (i + 1) + 32'(i) * 32'h0100_0003;
        end
        idle(6);
        sent = 0; got = 0; cyc = 0;
        stall_prev = 1'b0; saw_not_ready = 1'b0; held_sum = '0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 9);
            in_valid  = (sent < 6);
            a   = 32'h1111_1111 * (sent + 1);
            b   = 32'(sent) * 32'h0100_0003;
            cin = 1'b0; sub = 1'b0;
            #1;
            if (!i_ready[2]) saw_not_ready = 1'b1;
            if (stall_prev) chk("bp_hold_sum", o_sum[2], held_sum);
            if (o_valid[2] && out_ready) begin
                chk("bp_sum_in_order", o_sum[2], bp_exp[got]);
                got++;
            end
            stall_prev = o_valid[2] && !out_ready;
            held_sum   = o_sum[2];
            if (in_valid && i_ready[2]) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_result_count", got, 6);
        chk("bp_in_ready_dropped", saw_not_ready, 1);
        @(negedge clk); #1;
        chk("bp_no_duplicate", o_valid[2], 0);

        // Reset mid-stream: two ops in flight are dropped, a new op is accepted right after.
        idle(6);
        @(negedge clk);
        a = 32'h10; b = 32'h20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h30; b = 32'h40;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a = 32'h1; b = 32'h2; in_valid = 1'b1;
        #1;
        chk("rst_out_valid", o_valid[0], 0);
        chk("rst_in_ready", i_ready[0], 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        nres = 0;
        for (int k = 1; k <= 6; k++) begin
            if (o_valid[0]) begin
                nres++;
                chk("rst_new_sum", o_sum[0], 32'h3);
                chk("rst_new_latency", k, 2);
            end
            @(posedge clk); #1;
        end
        chk("rst_result_count", nres, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
